// File: rtl/gpu_vram_arbiter.sv
// VRAM arbiter between the GPU microcode engine and the CPU bus.
// GPU reads have priority; a wait counter bounds CPU starvation.
module gpu_vram_arbiter #(
    parameter int CPU_MAX_WAIT = 8
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iLcdEnable,
    input  logic [1:0]  iGpuState,
    input  logic        iGpuReq,
    input  logic [15:0] iGpuAddr,
    output logic [7:0]  oGpuData,
    output logic        oGpuAck,
    input  logic        iCpuReq,
    input  logic        iCpuWe,
    input  logic [15:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    output logic [7:0]  oCpuData,
    output logic        oCpuAck,
    output logic [12:0] oVramAddr,
    output logic        oVramWe,
    output logic [7:0]  oVramData,
    input  logic [7:0]  iVramData
);

    typedef enum logic [2:0] {
        S_IDLE, S_GPU_RD, S_CPU_RD, S_CPU_WR, S_CPU_BLK, S_DONE
    } state_e;

    // Which requester DONE completes, and what data it returns.
    typedef enum logic [1:0] {
        SRC_GPU, SRC_CPU_RD, SRC_CPU_NODATA, SRC_BLK_RD
    } src_e;

    localparam logic [3:0] MAX_WAIT = 4'(CPU_MAX_WAIT);

    state_e     state_q, state_d;
    src_e       src_q, src_d;
    logic [3:0] wait_q, wait_d;
    logic [7:0] gpu_data_q, gpu_data_d;
    logic [7:0] cpu_data_q, cpu_data_d;
    logic       blocked;
    logic       done;
    logic       unused_addr;

    assign unused_addr = ^{iGpuAddr[15:13], iCpuAddr[15:13]};
    assign blocked = iLcdEnable && (iGpuState == 2'd3);
    assign done = (state_q == S_DONE);

    // State, wait counter and held read data registers.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q    <= S_IDLE;
            src_q      <= SRC_GPU;
            wait_q     <= 4'd0;
            gpu_data_q <= 8'd0;
            cpu_data_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            wait_q     <= wait_d;
            gpu_data_q <= gpu_data_d;
            cpu_data_q <= cpu_data_d;
        end
    end

    // Arbitration decision in IDLE; fixed sequencing elsewhere.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (iCpuReq && (wait_q >= MAX_WAIT) && !blocked) begin
                    state_d = iCpuWe ? S_CPU_WR : S_CPU_RD;
                    src_d   = iCpuWe ? SRC_CPU_NODATA : SRC_CPU_RD;
                    wait_d  = 4'd0;
                end else if (iGpuReq) begin
                    state_d = S_GPU_RD;
                    src_d   = SRC_GPU;
                    if (iCpuReq && (wait_q != 4'd15))
                        wait_d = wait_q + 4'd1;
                end else if (iCpuReq && blocked) begin
                    state_d = S_CPU_BLK;
                    src_d   = iCpuWe ? SRC_CPU_NODATA : SRC_BLK_RD;
                    wait_d  = 4'd0;
                end else if (iCpuReq) begin
                    state_d = iCpuWe ? S_CPU_WR : S_CPU_RD;
                    src_d   = iCpuWe ? SRC_CPU_NODATA : SRC_CPU_RD;
                    wait_d  = 4'd0;
                end
            end
            S_GPU_RD, S_CPU_RD, S_CPU_WR, S_CPU_BLK: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // VRAM port drive for the granted access.
    always_comb begin
        oVramAddr = 13'd0;
        oVramWe   = 1'b0;
        oVramData = 8'd0;
        case (state_q)
            S_GPU_RD: oVramAddr = iGpuAddr[12:0];
            S_CPU_RD: oVramAddr = iCpuAddr[12:0];
            S_CPU_WR: begin
                oVramAddr = iCpuAddr[12:0];
                oVramWe   = 1'b1;
                oVramData = iCpuData;
            end
            default: ;
        endcase
    end

    // Completion pulses; read data is live during ack, then held.
    always_comb begin
        oGpuAck    = done && (src_q == SRC_GPU);
        oCpuAck    = done && (src_q != SRC_GPU);
        gpu_data_d = gpu_data_q;
        cpu_data_d = cpu_data_q;
        if (oGpuAck)
            gpu_data_d = iVramData;
        if (done && (src_q == SRC_CPU_RD))
            cpu_data_d = iVramData;
        if (done && (src_q == SRC_BLK_RD))
            cpu_data_d = 8'hFF;
        oGpuData = gpu_data_d;
        oCpuData = cpu_data_d;
    end

endmodule

// File: tb/tb_gpu_vram_arbiter.sv
// Directed testbench for gpu_vram_arbiter.
// Uses a behavioural synchronous VRAM with a backdoor preload port.
module tb_gpu_vram_arbiter;

    logic        iClock;
    logic        iReset;
    logic        iLcdEnable;
    logic [1:0]  iGpuState;
    logic        iGpuReq;
    logic [15:0] iGpuAddr;
    logic [7:0]  oGpuData;
    logic        oGpuAck;
    logic        iCpuReq;
    logic        iCpuWe;
    logic [15:0] iCpuAddr;
    logic [7:0]  iCpuData;
    logic [7:0]  oCpuData;
    logic        oCpuAck;
    logic [12:0] oVramAddr;
    logic        oVramWe;
    logic [7:0]  oVramData;
    logic [7:0]  iVramData;

    logic [7:0]  mem [0:8191];
    logic        bd_we;
    logic [12:0] bd_addr;
    logic [7:0]  bd_data;
    int          we_cnt = 0;
    int          tests = 0;
    int          fails = 0;

    gpu_vram_arbiter #(.CPU_MAX_WAIT(8)) dut (
        .iClock(iClock), .iReset(iReset),
        .iLcdEnable(iLcdEnable), .iGpuState(iGpuState),
        .iGpuReq(iGpuReq), .iGpuAddr(iGpuAddr),
        .oGpuData(oGpuData), .oGpuAck(oGpuAck),
        .iCpuReq(iCpuReq), .iCpuWe(iCpuWe),
        .iCpuAddr(iCpuAddr), .iCpuData(iCpuData),
        .oCpuData(oCpuData), .oCpuAck(oCpuAck),
        .oVramAddr(oVramAddr), .oVramWe(oVramWe),
        .oVramData(oVramData), .iVramData(iVramData)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    // Synchronous VRAM: one-cycle read latency.
    always @(posedge iClock) begin
        if (bd_we)
            mem[bd_addr] <= bd_data;
        else if (oVramWe)
            mem[oVramAddr] <= oVramData;
        iVramData <= mem[oVramAddr];
    end

    always @(posedge iClock)
        if (oVramWe) we_cnt <= we_cnt + 1;

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic backdoor(input logic [12:0] a, input logic [7:0] d);
        bd_we = 1'b1;
        bd_addr = a;
        bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic test_reset();
        iReset = 1'b1;
        #1 iReset = 1'b0;
        #2;
        tests++;
        if ({oGpuAck, oCpuAck, oVramWe} !== 3'b000) begin
            fails++;
            $display("FAIL reset_strobes: got %b expected 000",
                     {oGpuAck, oCpuAck, oVramWe});
        end
        tests++;
        if ({oVramAddr, oVramData, oGpuData, oCpuData} !== 37'd0) begin
            fails++;
            $display("FAIL reset_buses: addr %h vd %h gd %h cd %h expected 0",
                     oVramAddr, oVramData, oGpuData, oCpuData);
        end
        tick();
        tick();
        iReset = 1'b1;
        tick();
    endtask

    task automatic test_gpu_read();
        backdoor(13'h1800, 8'h5A);
        iGpuReq = 1'b1;
        iGpuAddr = 16'h9800;
        tick();
        tests++;
        if (oVramAddr !== 13'h1800 || oVramWe !== 1'b0 || oGpuAck !== 1'b0) begin
            fails++;
            $display("FAIL gpu_addr: addr %h we %b ack %b expected 1800 0 0",
                     oVramAddr, oVramWe, oGpuAck);
        end
        tick();
        tests++;
        if (oGpuAck !== 1'b1 || oGpuData !== 8'h5A || oCpuAck !== 1'b0) begin
            fails++;
            $display("FAIL gpu_ack: ack %b data %h cack %b expected 1 5a 0",
                     oGpuAck, oGpuData, oCpuAck);
        end
        iGpuReq = 1'b0;
        tick();
        tests++;
        if (oGpuAck !== 1'b0 || oGpuData !== 8'h5A) begin
            fails++;
            $display("FAIL gpu_hold: ack %b data %h expected 0 5a",
                     oGpuAck, oGpuData);
        end
    endtask

    task automatic test_cpu_write();
        int w0;
        w0 = we_cnt;
        iCpuReq = 1'b1;
        iCpuWe = 1'b1;
        iCpuAddr = 16'h8010;
        iCpuData = 8'h3C;
        tick();
        tests++;
        if (oVramWe !== 1'b1 || oVramAddr !== 13'h0010 ||
            oVramData !== 8'h3C || oCpuAck !== 1'b0) begin
            fails++;
            $display("FAIL cpu_wr_cycle: we %b addr %h d %h ack %b expected 1 0010 3c 0",
                     oVramWe, oVramAddr, oVramData, oCpuAck);
        end
        tick();
        tests++;
        if (oVramWe !== 1'b0 || oCpuAck !== 1'b1) begin
            fails++;
            $display("FAIL cpu_wr_ack: we %b ack %b expected 0 1", oVramWe, oCpuAck);
        end
        iCpuReq = 1'b0;
        iCpuWe = 1'b0;
        tick();
        tests++;
        if (we_cnt - w0 !== 1) begin
            fails++;
            $display("FAIL cpu_wr_pulses: got %0d expected 1", we_cnt - w0);
        end
        iCpuReq = 1'b1;
        tick();
        tests++;
        if (oVramAddr !== 13'h0010 || oVramWe !== 1'b0) begin
            fails++;
            $display("FAIL cpu_rd_addr: addr %h we %b expected 0010 0",
                     oVramAddr, oVramWe);
        end
        tick();
        tests++;
        if (oCpuAck !== 1'b1 || oCpuData !== 8'h3C) begin
            fails++;
            $display("FAIL cpu_readback: ack %b data %h expected 1 3c",
                     oCpuAck, oCpuData);
        end
        iCpuReq = 1'b0;
        tick();
    endtask

    task automatic test_lockout();
        int w0;
        backdoor(13'h0020, 8'h77);
        iLcdEnable = 1'b1;
        iGpuState = 2'd3;
        w0 = we_cnt;
        iCpuReq = 1'b1;
        iCpuWe = 1'b0;
        iCpuAddr = 16'h8020;
        tick();
        tests++;
        if (oVramWe !== 1'b0 || oVramAddr !== 13'd0 || oCpuAck !== 1'b0) begin
            fails++;
            $display("FAIL blk_rd_idle: we %b addr %h ack %b expected 0 0 0",
                     oVramWe, oVramAddr, oCpuAck);
        end
        tick();
        tests++;
        if (oCpuAck !== 1'b1 || oCpuData !== 8'hFF) begin
            fails++;
            $display("FAIL blk_rd_ack: ack %b data %h expected 1 ff",
                     oCpuAck, oCpuData);
        end
        iCpuReq = 1'b0;
        tick();
        tests++;
        if (oCpuData !== 8'hFF) begin
            fails++;
            $display("FAIL blk_rd_hold: data %h expected ff", oCpuData);
        end
        iCpuReq = 1'b1;
        iCpuWe = 1'b1;
        iCpuData = 8'h11;
        tick();
        tick();
        tests++;
        if (oCpuAck !== 1'b1) begin
            fails++;
            $display("FAIL blk_wr_ack: ack %b expected 1", oCpuAck);
        end
        iCpuReq = 1'b0;
        iCpuWe = 1'b0;
        tick();
        tests++;
        if (we_cnt - w0 !== 0) begin
            fails++;
            $display("FAIL blk_wr_strobe: pulses %0d expected 0", we_cnt - w0);
        end
        iLcdEnable = 1'b0;
        iGpuState = 2'd0;
        iCpuReq = 1'b1;
        tick();
        tick();
        tests++;
        if (oCpuAck !== 1'b1 || oCpuData !== 8'h77) begin
            fails++;
            $display("FAIL blk_wr_dropped: ack %b data %h expected 1 77",
                     oCpuAck, oCpuData);
        end
        iCpuReq = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        int g;
        int seen;
        int runs [2];
        logic [7:0] cd [2];
        g = 0;
        seen = 0;
        runs[0] = -1;
        runs[1] = -1;
        cd[0] = 8'h00;
        cd[1] = 8'h00;
        iGpuReq = 1'b1;
        iGpuAddr = 16'h9800;
        iCpuReq = 1'b1;
        iCpuWe = 1'b0;
        iCpuAddr = 16'h8010;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (oGpuAck) g++;
            if (oCpuAck) begin
                runs[seen] = g;
                cd[seen] = oCpuData;
                g = 0;
                seen++;
                if (seen == 2) break;
            end
        end
        iGpuReq = 1'b0;
        iCpuReq = 1'b0;
        tick();
        tests++;
        if (seen !== 2) begin
            fails++;
            $display("FAIL starve_timeout: cpu acks %0d expected 2", seen);
        end
        tests++;
        if (runs[0] !== 8 || cd[0] !== 8'h3C) begin
            fails++;
            $display("FAIL starve_first: gpu acks %0d data %h expected 8 3c",
                     runs[0], cd[0]);
        end
        tests++;
        if (runs[1] !== 8 || cd[1] !== 8'h3C) begin
            fails++;
            $display("FAIL starve_rearm: gpu acks %0d data %h expected 8 3c",
                     runs[1], cd[1]);
        end
    endtask

    task automatic test_simultaneous();
        logic [12:0] a [5];
        logic        ga [5];
        logic        ca [5];
        logic [7:0]  gd;
        logic [7:0]  cd;
        gd = 8'h00;
        cd = 8'h00;
        iGpuReq = 1'b1;
        iGpuAddr = 16'h9800;
        iCpuReq = 1'b1;
        iCpuWe = 1'b0;
        iCpuAddr = 16'h8010;
        for (int i = 0; i < 5; i++) begin
            tick();
            a[i] = oVramAddr;
            ga[i] = oGpuAck;
            ca[i] = oCpuAck;
            if (oGpuAck) begin
                gd = oGpuData;
                iGpuReq = 1'b0;
            end
            if (oCpuAck) begin
                cd = oCpuData;
                iCpuReq = 1'b0;
            end
        end
        tick();
        tests++;
        if (a[0] !== 13'h1800 || a[3] !== 13'h0010) begin
            fails++;
            $display("FAIL simul_addr: n1 %h n4 %h expected 1800 0010", a[0], a[3]);
        end
        tests++;
        if ({ga[0], ga[1], ga[2], ga[3], ga[4]} !== 5'b01000 || gd !== 8'h5A) begin
            fails++;
            $display("FAIL simul_gpu_ack: acks %b data %h expected 01000 5a",
                     {ga[0], ga[1], ga[2], ga[3], ga[4]}, gd);
        end
        tests++;
        if ({ca[0], ca[1], ca[2], ca[3], ca[4]} !== 5'b00001 || cd !== 8'h3C) begin
            fails++;
            $display("FAIL simul_cpu_ack: acks %b data %h expected 00001 3c",
                     {ca[0], ca[1], ca[2], ca[3], ca[4]}, cd);
        end
    endtask

    task automatic test_reset_mid_write();
        backdoor(13'h0030, 8'h44);
        iCpuReq = 1'b1;
        iCpuWe = 1'b1;
        iCpuAddr = 16'h8030;
        iCpuData = 8'h99;
        tick();
        tests++;
        if (oVramWe !== 1'b1) begin
            fails++;
            $display("FAIL rst_wr_start: we %b expected 1", oVramWe);
        end
        #1 iReset = 1'b0;
        #1;
        tests++;
        if ({oVramWe, oCpuAck, oGpuAck} !== 3'b000 ||
            {oVramAddr, oVramData, oGpuData, oCpuData} !== 37'd0) begin
            fails++;
            $display("FAIL rst_async: we %b ca %b ga %b addr %h vd %h gd %h cd %h expected all 0",
                     oVramWe, oCpuAck, oGpuAck, oVramAddr, oVramData, oGpuData, oCpuData);
        end
        iCpuReq = 1'b0;
        iCpuWe = 1'b0;
        tick();
        tests++;
        if (oCpuAck !== 1'b0) begin
            fails++;
            $display("FAIL rst_no_ack: ack %b expected 0", oCpuAck);
        end
        iReset = 1'b1;
        tick();
        iCpuReq = 1'b1;
        tick();
        tick();
        tests++;
        if (oCpuAck !== 1'b1 || oCpuData !== 8'h44) begin
            fails++;
            $display("FAIL rst_wr_aborted: ack %b data %h expected 1 44",
                     oCpuAck, oCpuData);
        end
        iCpuReq = 1'b0;
        tick();
    endtask

    initial begin
        iLcdEnable = 1'b0;
        iGpuState = 2'd0;
        iGpuReq = 1'b0;
        iGpuAddr = 16'h0;
        iCpuReq = 1'b0;
        iCpuWe = 1'b0;
        iCpuAddr = 16'h0;
        iCpuData = 8'h0;
        bd_we = 1'b0;
        bd_addr = 13'h0;
        bd_data = 8'h0;
        test_reset();
        test_gpu_read();
        test_cpu_write();
        test_lockout();
        test_starvation();
        test_simultaneous();
        test_reset_mid_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpu_vram_arbiter.md
# gpu_vram_arbiter

Arbitrates single-port VRAM (8 KB, 0x8000–0x9FFF) between the CPU bus and the GPU microcode engine's `grvmem` reads. GPU reads have priority. A wait counter keeps the CPU from being starved. During the VRAM-read scanline state with the LCD enabled, CPU accesses are locked out: reads return 0xFF and writes are dropped. The block sits between the GPU core, the CPU memory decoder and the VRAM macro.

## Interface
Parameters:
- CPU_MAX_WAIT, 8: number of lost arbitration cycles after which the CPU is forced a grant (range 1–15).

Ports:
- iClock  in  1  system clock.
- iReset  in  1  asynchronous, active-low reset.
- iLcdEnable  in  1  LCDC[7].
- iGpuState  in  2  GPU scanline state; 3 = SCANLINE_VRAM_READ.
- iGpuReq  in  1  GPU read request; held until oGpuAck.
- iGpuAddr  in  16  GPU VRAM address; bits [12:0] are used.
- oGpuData  out  8  read data; valid while oGpuAck = 1 and held afterwards.
- oGpuAck  out  1  one-cycle completion pulse.
- iCpuReq  in  1  CPU request, already VRAM-decoded; held until oCpuAck.
- iCpuWe  in  1  1 = write, 0 = read.
- iCpuAddr  in  16  CPU address; bits [12:0] are used.
- iCpuData  in  8  write data.
- oCpuData  out  8  read data; valid while oCpuAck = 1 and held afterwards.
- oCpuAck  out  1  one-cycle completion pulse.
- oVramAddr  out  13  VRAM address.
- oVramWe  out  1  VRAM write strobe.
- oVramData  out  8  VRAM write data.
- iVramData  in  8  VRAM synchronous read data, valid one cycle after the address.

## Operation
- States: IDLE, GPU_RD, CPU_RD, CPU_WR, CPU_BLK, DONE.
- Lockout condition: blocked = iLcdEnable && (iGpuState == 3).
- IDLE decision, in priority order:
  1. iCpuReq && wait_cnt >= CPU_MAX_WAIT && !blocked → CPU_RD or CPU_WR.
  2. iGpuReq → GPU_RD. If iCpuReq is also high, wait_cnt increments, saturating at 15.
  3. iCpuReq && blocked → CPU_BLK.
  4. iCpuReq → CPU_RD if iCpuWe = 0, CPU_WR if iCpuWe = 1.
  5. Otherwise stay in IDLE.
- Any CPU grant (CPU_RD, CPU_WR or CPU_BLK) clears wait_cnt.
- Forced CPU grant under lockout: when wait_cnt is saturated but blocked = 1, the GPU still wins. The counter resumes only after the lockout ends.
- GPU_RD / CPU_RD:
  - oVramAddr = requester addr[12:0], oVramWe = 0.
  - Next state DONE; DONE latches iVramData into the requester's data register and pulses that requester's ack.
- CPU_WR:
  - oVramAddr = iCpuAddr[12:0], oVramData = iCpuData, oVramWe = 1 for exactly this cycle.
  - Next state DONE, which pulses oCpuAck.
- CPU_BLK:
  - No VRAM activity (oVramWe = 0).
  - Next state DONE: a read returns oCpuData = 8'hFF; a write is discarded. oCpuAck pulses in both cases.
- DONE always returns to IDLE. Requests are not sampled in DONE. The requester deasserts req in the cycle after ack, or keeps it asserted to start a new access.
- Address bits [15:13] are ignored.

## Timing
- Request high in IDLE at edge N → VRAM address driven in cycle N+1 → ack high in cycle N+2.
- Latency is 2 cycles from the sampling edge to ack for every access type.
- Throughput is one access per 3 cycles.
- Simultaneous GPU and CPU requests: the GPU is served first. The CPU is decided at the next IDLE cycle, N+3.
- Changes to iGpuState or iLcdEnable only take effect at the IDLE decision. An in-flight access always completes, including a CPU_WR started just before the state turns to 3.
- Reset, asynchronous and active-low:
  - State goes to IDLE; wait_cnt goes to 0.
  - oGpuAck, oCpuAck, oVramWe = 0; oVramAddr = 0; oVramData = 0; oGpuData = 0; oCpuData = 0.
  - Reset mid-access aborts the access with no ack. A reset asserted during CPU_WR drops oVramWe immediately.

## Test plan
- GPU read 0x9800 with VRAM[0x1800] = 0x5A → oVramAddr = 0x1800 in cycle N+1; oGpuAck and oGpuData = 0x5A in cycle N+2.
- CPU write 0x8010 ← 0x3C with iGpuState = 0 → oVramWe high for exactly 1 cycle with addr 0x0010; oCpuAck at N+2; a readback returns 0x3C.
- iLcdEnable = 1, iGpuState = 3: CPU read → oCpuData = 0xFF, oCpuAck, no VRAM cycle. CPU write → dropped; VRAM unchanged and oVramWe never asserted.
- GPU request held continuously plus a CPU read with iGpuState = 0 → the CPU is granted after exactly 8 GPU accesses; wait_cnt returns to 0.
- GPU and CPU requests in the same cycle → GPU ack at N+2; CPU address driven at N+4; CPU ack at N+5.
- Assert iReset mid-CPU_WR → oVramWe = 0 asynchronously, no ack, and all outputs at their reset values.
